// File: rtl/sr_lru_pkg.sv
// Shared constants, command encoding and reset-order helper for the sr_lru responder.
package sr_lru_pkg;

    localparam int unsigned LRU_DEMOTE_BIT = 7;
    localparam int unsigned MAX_WAYS       = 8;
    localparam int unsigned MAX_IDX_W      = 3;

    // Encoded as {read, write, demote}; pop wins whenever read is set.
    typedef enum logic [2:0] {
        CMD_IDLE   = 3'b000,
        CMD_TOUCH  = 3'b010,
        CMD_DEMOTE = 3'b011,
        CMD_POP    = 3'b100
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic rd, input logic wr, input logic demote);
        if (rd)
            return CMD_POP;
        if (wr)
            return demote ? CMD_DEMOTE : CMD_TOUCH;
        return CMD_IDLE;
    endfunction

    // Flattened identity permutation: slot i holds index i.
    function automatic logic [MAX_WAYS*MAX_IDX_W-1:0] rst_order(input int unsigned ways,
                                                                input int unsigned idx_w);
        logic [MAX_WAYS*MAX_IDX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < ways; i++)
            v |= (MAX_WAYS*MAX_IDX_W)'(i) << (i * idx_w);
        return v;
    endfunction

endpackage

// File: rtl/sr_lru_find.sv
// Combinational search for the position of an index in the recency order, plus shift masks.
module sr_lru_find
    import sr_lru_pkg::*;
#(
    parameter int unsigned WAYS  = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WAYS*IDX_W-1:0] order_i,
    input  logic [IDX_W-1:0]      addr_i,
    output logic [IDX_W-1:0]      pos_o,
    output logic [WAYS-1:0]       le_mask_o,
    output logic [WAYS-1:0]       ge_mask_o
);

    logic [WAYS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < WAYS; i++)
            hit[i] = (order_i[i*IDX_W +: IDX_W] == addr_i);
    end

    always_comb begin
        pos_o = '0;
        for (int unsigned i = 0; i < WAYS; i++)
            if (hit[i])
                pos_o = IDX_W'(i);
    end

    // le_mask_o[i]: match at or beyond i; ge_mask_o[i]: match at or before i.
    always_comb begin
        le_mask_o = '0;
        ge_mask_o = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            le_mask_o[i] = |(hit >> i);
            ge_mask_o[i] = |(hit << (WAYS - 1 - i));
        end
    end

endmodule

// File: rtl/sr_lru.sv
// LRU-port responder: recency order of WAYS indices with pop/touch/demote updates.
// Optional pop/touch statistics counters enabled by defining SR_LRU_STATS_EN.
module sr_lru
    import sr_lru_pkg::*;
#(
    parameter int unsigned WAYS   = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lruWrite,
    input  logic              lruRead,
    input  logic [2:0]        lruAddr,
    input  logic [DATA_W-1:0] lruIn,
    output logic [DATA_W-1:0] lruOut,
    output logic              lruErr
`ifdef SR_LRU_STATS_EN
    ,
    output logic [15:0]       popCnt,
    output logic [15:0]       touchCnt
`endif
);

    localparam logic [WAYS*IDX_W-1:0] RST_ORDER = (WAYS*IDX_W)'(rst_order(WAYS, IDX_W));

    logic [IDX_W-1:0]      order_q [WAYS];
    logic [IDX_W-1:0]      order_d [WAYS];
    logic                  err_q;
    logic                  err_d;
    logic [WAYS*IDX_W-1:0] order_flat;
    logic [IDX_W-1:0]      addr;
    logic [IDX_W-1:0]      find_pos;
    logic [WAYS-1:0]       le_mask;
    logic [WAYS-1:0]       ge_mask;
    cmd_e                  cmd;
    logic                  unused_bits;

    assign addr        = lruAddr[IDX_W-1:0];
    assign unused_bits = ^{lruIn, find_pos, lruAddr};

    always_comb begin
        order_flat = '0;
        for (int unsigned i = 0; i < WAYS; i++)
            order_flat[i*IDX_W +: IDX_W] = order_q[i];
    end

    sr_lru_find #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_find (
        .order_i   (order_flat),
        .addr_i    (addr),
        .pos_o     (find_pos),
        .le_mask_o (le_mask),
        .ge_mask_o (ge_mask)
    );

    always_comb begin
        cmd     = decode_cmd(lruRead, lruWrite, lruIn[LRU_DEMOTE_BIT]);
        order_d = order_q;
        err_d   = err_q | (lruRead & lruWrite);
        case (cmd)
            CMD_POP: begin
                order_d[0] = order_q[WAYS-1];
                for (int unsigned i = 1; i < WAYS; i++)
                    order_d[i] = order_q[i-1];
            end
            CMD_TOUCH: begin
                order_d[0] = addr;
                for (int unsigned i = 1; i < WAYS; i++)
                    if (le_mask[i])
                        order_d[i] = order_q[i-1];
            end
            CMD_DEMOTE: begin
                order_d[WAYS-1] = addr;
                for (int unsigned i = 0; i < WAYS - 1; i++)
                    if (ge_mask[i])
                        order_d[i] = order_q[i+1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WAYS; i++)
                order_q[i] <= RST_ORDER[i*IDX_W +: IDX_W];
            err_q <= 1'b0;
        end else begin
            order_q <= order_d;
            err_q   <= err_d;
        end
    end

    assign lruOut = DATA_W'(order_q[WAYS-1]);
    assign lruErr = err_q;

`ifdef SR_LRU_STATS_EN
    logic [15:0] pop_cnt_q;
    logic [15:0] touch_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_cnt_q   <= '0;
            touch_cnt_q <= '0;
        end else begin
            if (cmd == CMD_POP && pop_cnt_q != '1)
                pop_cnt_q <= pop_cnt_q + 16'd1;
            if ((cmd == CMD_TOUCH || cmd == CMD_DEMOTE) && touch_cnt_q != '1)
                touch_cnt_q <= touch_cnt_q + 16'd1;
        end
    end

    assign popCnt   = pop_cnt_q;
    assign touchCnt = touch_cnt_q;
`endif

endmodule

// File: tb/tb_sr_lru.sv
// Scoreboard bench for sr_lru: queue-based recency model, directed sequences then random traffic.
module tb_sr_lru;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lruWrite = 1'b0;
    logic       lruRead = 1'b0;
    logic [2:0] lruAddr = '0;
    logic [7:0] lruIn = '0;
    logic [7:0] lruOut;
    logic       lruErr;
`ifdef SR_LRU_STATS_EN
    logic [15:0] popCnt;
    logic [15:0] touchCnt;
`endif

    always #5 clk = ~clk;

    sr_lru #(
        .WAYS   (8),
        .IDX_W  (3),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lruWrite (lruWrite),
        .lruRead  (lruRead),
        .lruAddr  (lruAddr),
        .lruIn    (lruIn),
        .lruOut   (lruOut),
        .lruErr   (lruErr)
`ifdef SR_LRU_STATS_EN
        ,
        .popCnt   (popCnt),
        .touchCnt (touchCnt)
`endif
    );

    typedef struct {
        bit          chk;
        logic [7:0]  out;
        logic        err;
        logic [15:0] pc;
        logic [15:0] tc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference: queue front = most recent, back = least recent.
    int   model[$];
    bit   m_err = 0;
    int   m_pc = 0;
    int   m_tc = 0;
    bit   m_known = 0;

    task automatic step(input bit rst, input bit rd, input bit wr, input int addr,
                        input bit dem, input string tag);
        exp_t e;
        int   v;
        int   k;
        @(posedge clk);
        #1;
        rst_n    = !rst;
        lruRead  = rd;
        lruWrite = wr;
        lruAddr  = 3'(addr);
        lruIn    = {dem, 7'($urandom)};
        e.chk = m_known;
        e.out = m_known ? 8'(model[$]) : 8'd0;
        e.err = m_err;
        e.pc  = 16'(m_pc);
        e.tc  = 16'(m_tc);
        e.tag = tag;
        sb.push_back(e);
        if (rst) begin
            model   = {0, 1, 2, 3, 4, 5, 6, 7};
            m_err   = 0;
            m_pc    = 0;
            m_tc    = 0;
            m_known = 1;
        end else if (m_known && rd) begin
            v = model.pop_back();
            model.push_front(v);
            if (wr) m_err = 1;
            if (m_pc < 65535) m_pc++;
        end else if (m_known && wr) begin
            k = 0;
            for (int i = 0; i < model.size(); i++)
                if (model[i] == addr) k = i;
            model.delete(k);
            if (dem) model.push_back(addr);
            else     model.push_front(addr);
            if (m_tc < 65535) m_tc++;
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, tag);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                total++;
                if (lruOut !== e.out) begin
                    bad++;
                    $display("FAIL %s lruOut got=%0d want=%0d @%0t", e.tag, lruOut, e.out, $time);
                end
                total++;
                if (lruErr !== e.err) begin
                    bad++;
                    $display("FAIL %s lruErr got=%0b want=%0b @%0t", e.tag, lruErr, e.err, $time);
                end
`ifdef SR_LRU_STATS_EN
                total++;
                if (popCnt !== e.pc) begin
                    bad++;
                    $display("FAIL %s popCnt got=%0d want=%0d @%0t", e.tag, popCnt, e.pc, $time);
                end
                total++;
                if (touchCnt !== e.tc) begin
                    bad++;
                    $display("FAIL %s touchCnt got=%0d want=%0d @%0t", e.tag, touchCnt, e.tc, $time);
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        step(1, 0, 0, 0, 0, "reset");
        idle(3, "reset_idle");

        step(1, 0, 0, 0, 0, "pop_rst");
        step(0, 1, 0, 0, 0, "pop1");
        step(0, 1, 0, 0, 0, "pop2");
        idle(1, "pop_after");

        step(1, 0, 0, 0, 0, "touch_rst");
        step(0, 0, 1, 6, 0, "touch6");
        step(0, 0, 1, 7, 0, "touch7");
        step(0, 0, 1, 0, 0, "touch0_mru");
        step(0, 0, 1, 0, 0, "touch0_again");
        idle(1, "touch_after");

        step(1, 0, 0, 0, 0, "demote_rst");
        step(0, 0, 1, 0, 1, "demote0");
        step(0, 0, 1, 0, 1, "demote0_again");
        step(0, 1, 0, 0, 0, "pop_demoted");
        idle(1, "demote_after");

        step(1, 0, 0, 0, 0, "coll_rst");
        step(0, 1, 1, 3, 0, "collision");
        idle(10, "err_hold");

        step(0, 0, 1, 2, 0, "mid_touch");
        step(0, 1, 0, 0, 0, "mid_pop");
        step(0, 0, 1, 5, 1, "mid_demote");
        step(1, 0, 0, 0, 0, "mid_rst");
        idle(1, "mid_rst_after");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "pop3");
        idle(1, "pop3_after");

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(99);
            if (r < 2)       step(1, 0, 0, 0, 0, "rnd_rst");
            else if (r < 7)  step(0, 1, 1, $urandom_range(7), $urandom_range(1), "rnd_coll");
            else if (r < 35) step(0, 1, 0, $urandom_range(7), 0, "rnd_pop");
            else if (r < 60) step(0, 0, 1, $urandom_range(7), 0, "rnd_touch");
            else if (r < 82) step(0, 0, 1, $urandom_range(7), 1, "rnd_demote");
            else             step(0, 0, 0, $urandom_range(7), 0, "rnd_idle");
        end
        idle(1, "final");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
